// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes strobed in by tx_flag are queued in a
// small FIFO and sent back-to-back on the tx line at CLK_FREQ/BAUD_RATE cycles per bit.
module uart_tx_buf #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          tx_flag,
    input  logic [7:0]                    tx_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          ovf
);

    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = PW + 1;
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int BW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;

    logic          bit_end;
    logic          stop_end;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          busy_d;

    assign bit_end  = (baud_q == BW'(BIT_CYCLES - 1));
    assign stop_end = (state_q == STOP) && bit_end;
    assign pop      = (cnt_q != '0) && ((state_q == IDLE) || stop_end);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
    assign wr_en    = tx_flag && (!full || pop);

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Mirrors the next-state FSM activity so busy flips on the same edge as state/count.
    assign busy_d = pop || !((state_q == IDLE) || stop_end) || (cnt_d != '0);

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (tx_flag && !wr_en) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Line output follows the current state one edge later, keeping tx glitch-free.
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[bit_q];
                default: tx_q <= 1'b1;
            endcase
            done_q <= stop_end;
            busy_q <= busy_d;

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            bit_q   <= '0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;
    assign fifo_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: frame-timeline reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a random phase.
module tb_uart_tx_buf;

    localparam int CLK_FREQ   = 16;
    localparam int BAUD_RATE  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int BC         = CLK_FREQ / BAUD_RATE;
    localparam int FL         = 10 * BC;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          tx_flag = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx;
    logic          busy;
    logic          tx_done;
    logic [CW-1:0] fifo_cnt;
    logic          ovf;

    int checks     = 0;
    int failures   = 0;
    int cmp_prints = 0;

    uart_tx_buf #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tx_flag (tx_flag),
        .tx_data (tx_data),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done),
        .fifo_cnt(fifo_cnt),
        .ovf     (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: a byte queue plus the age (in edges) of the frame on the
    // line since its byte was popped; the line shows frame cycle k after pop edge + k.
    byte unsigned mq[$];
    logic [7:0]   m_cur   = 8'h00;
    int           m_age   = 1000;
    logic         m_ovf   = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_valid = 1'b0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            mq.delete();
            m_age   = 1000;
            m_ovf   = 1'b0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else begin
            bit m_pop;
            bit m_wr;
            int sz;
            sz     = mq.size();
            m_done = (m_age == FL - 1);
            m_pop  = (sz > 0) && (m_age >= FL - 1);
            m_wr   = tx_flag && ((sz < FIFO_DEPTH) || m_pop);
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_age = 0;
            end else if (m_age < 1000) begin
                m_age++;
            end
            if (m_wr) mq.push_back(tx_data);
            else if (tx_flag) m_ovf = 1'b1;
        end
    end

    function automatic logic m_tx();
        int b;
        if (m_age >= 1 && m_age <= FL) begin
            b = (m_age - 1) / BC;
            if (b == 0) return 1'b0;
            if (b <= 8) return m_cur[b-1];
        end
        return 1'b1;
    endfunction

    always @(negedge sys_clk) begin
        if (m_valid) begin
            logic [CW+3:0] exp_v;
            logic [CW+3:0] got_v;
            exp_v = {m_tx(), ((m_age < FL) || (mq.size() != 0)), m_done, CW'(mq.size()), m_ovf};
            got_v = {tx, busy, tx_done, fifo_cnt, ovf};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                if (cmp_prints < 20) begin
                    cmp_prints++;
                    $display("FAIL model_cmp t=%0t {tx,busy,done,cnt,ovf} got=%b required=%b",
                             $time, got_v, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_bits;
        int peak, ndone, first_low, last_done, nlow;

        // Reset values
        sys_rst = 1'b1;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", tx_done, 0);

        // Single byte, strobed on the first edge with reset low
        sys_rst = 1'b0;
        tx_flag = 1'b1;
        tx_data = 8'hA5;
        tick();
        tx_flag = 1'b0;
        chk("first_accept_cnt", fifo_cnt, 1);
        chk("first_accept_busy", busy, 1);
        chk("first_tx_idle", tx, 1);
        tick();
        chk("pop_cnt", fifo_cnt, 0);
        chk("tx_before_start", tx, 1);
        tick();
        chk("latency_tx_low", tx, 0);
        exp_bits = 10'b11_0100_1010;
        for (int b = 0; b < 10; b++) begin
            repeat (8) tick();
            chk($sformatf("a5_bit%0d", b), tx, int'(exp_bits[b]));
            if (b < 9) begin
                repeat (8) tick();
            end else begin
                chk("a5_done_early", tx_done, 0);
                repeat (7) tick();
                chk("a5_done_at_160", tx_done, 1);
                tick();
                chk("a5_done_clear", tx_done, 0);
                chk("a5_busy_after", busy, 0);
            end
        end

        // Burst of three bytes on consecutive cycles
        repeat (5) tick();
        tx_flag = 1'b1;
        tx_data = 8'h01;
        tick();
        tx_data = 8'h02;
        tick();
        tx_data = 8'h03;
        tick();
        tx_flag   = 1'b0;
        peak      = 0;
        ndone     = 0;
        first_low = -1;
        last_done = -1;
        for (int i = 0; i < 600; i++) begin
            if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
            if (tx == 1'b0 && first_low < 0) first_low = i;
            if (tx_done) begin
                ndone++;
                last_done = i;
            end
            tick();
        end
        chk("burst_peak_cnt", peak, 2);
        chk("burst_done_count", ndone, 3);
        chk("burst_span", last_done - first_low + 1, 3 * FL);

        // Overflow: six strobes from idle
        do_reset();
        tx_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'h10 + 8'(i);
            tick();
        end
        tx_flag = 1'b0;
        chk("ovf_set", ovf, 1);
        chk("ovf_cnt_full", fifo_cnt, 4);
        ndone = 0;
        for (int i = 0; i < 1000; i++) begin
            if (tx_done) ndone++;
            tick();
        end
        chk("ovf_frames", ndone, 5);
        chk("ovf_sticky", ovf, 1);
        do_reset();
        chk("ovf_cleared", ovf, 0);

        // Full FIFO with a strobe landing on the end-of-stop pop edge
        tx_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h20 + 8'(i);
            tick();
        end
        tx_flag = 1'b0;
        chk("fullpop_pre_cnt", fifo_cnt, 4);
        repeat (156) tick();
        tx_flag = 1'b1;
        tx_data = 8'h77;
        tick();
        tx_flag = 1'b0;
        chk("fullpop_cnt", fifo_cnt, 4);
        chk("fullpop_ovf", ovf, 0);
        chk("fullpop_done", tx_done, 1);
        repeat (6 * FL) tick();
        chk("fullpop_drained", busy, 0);

        // Reset in the middle of DATA bit 3 with two bytes queued
        do_reset();
        tx_flag = 1'b1;
        tx_data = 8'h00;
        tick();
        tx_data = 8'h55;
        tick();
        tx_data = 8'hAA;
        tick();
        tx_flag = 1'b0;
        repeat (68) tick();
        chk("midrst_bit3_low", tx, 0);
        chk("midrst_queued", fifo_cnt, 2);
        sys_rst = 1'b1;
        tick();
        chk("midrst_tx", tx, 1);
        chk("midrst_cnt", fifo_cnt, 0);
        chk("midrst_busy", busy, 0);
        sys_rst = 1'b0;
        nlow  = 0;
        ndone = 0;
        for (int i = 0; i < 400; i++) begin
            if (tx == 1'b0) nlow++;
            if (tx_done) ndone++;
            tick();
        end
        chk("midrst_no_frames", nlow + ndone, 0);

        // Randomized phase: dense, paced and heavy traffic with rare resets
        for (int blk = 0; blk < 15; blk++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 2000; i++) begin
                case (mode)
                    0:       tx_flag = ($urandom_range(0, 19) == 0);
                    1:       tx_flag = ($urandom_range(0, 199) == 0);
                    default: tx_flag = ($urandom_range(0, 3) == 0);
                endcase
                tx_data = 8'($urandom);
                sys_rst = ($urandom_range(0, 4999) == 0);
                tick();
            end
        end
        tx_flag = 1'b0;
        sys_rst = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
